// File: rtl/dac_spi_monitor_if.sv
// Galvo DAC SPI bus plus the decoded position/status outputs of the monitor.
//   master : drives the SPI pins (projector core / bench), observes results
//   slave  : dac_spi_monitor, listens to the pins and drives the results
//   dac_csn/dac_sclk/dac_mosi/dac_latchn : raw DAC bus pins
//   pos_x/pos_y     : latched channel A/B codes
//   pos_valid       : one-cycle pulse on a position update
//   chan_shdn       : latched shutdown state, [0] = A, [1] = B
//   frame_err       : one-cycle pulse on a malformed frame
//   err_count       : saturating frame error count
interface dac_spi_monitor_if;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned ERR_W  = 8;

    logic              dac_csn;
    logic              dac_sclk;
    logic              dac_mosi;
    logic              dac_latchn;
    logic [CODE_W-1:0] pos_x;
    logic [CODE_W-1:0] pos_y;
    logic              pos_valid;
    logic [1:0]        chan_shdn;
    logic              frame_err;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output dac_csn, dac_sclk, dac_mosi, dac_latchn,
        input  pos_x, pos_y, pos_valid, chan_shdn, frame_err, err_count
    );

    modport slave (
        input  dac_csn, dac_sclk, dac_mosi, dac_latchn,
        output pos_x, pos_y, pos_valid, chan_shdn, frame_err, err_count
    );
endinterface

// File: rtl/dac_spi_monitor.sv
// Passive monitor of the dual-channel galvo DAC SPI bus. Deserializes 16-bit
// frames into per-channel input registers and transfers them to the reported
// X/Y position on the falling edge of the latch strobe, like the DAC itself.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : dac_spi_monitor_if.slave (SPI pins in, position/status out)
module dac_spi_monitor #(
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    dac_spi_monitor_if.slave    bus
);
    localparam int unsigned CODE_W   = 12;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned CNT_MAX  = 31;
    localparam int unsigned CHAN_BIT = 15;
    localparam int unsigned SHDN_BIT = 12;

    typedef struct packed {
        logic              shdn_n;
        logic [CODE_W-1:0] code;
    } in_reg_t;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    // Input synchronizers and previous-value registers for edge detection
    logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, mosi_sync_q, latchn_sync_q;
    logic csn_prev_q, sclk_prev_q, latchn_prev_q;
    logic csn_s, sclk_s, mosi_s, latchn_s;
    logic csn_rise, csn_fall, sclk_rise, latchn_fall;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    in_reg_t              in_a_q, in_a_d, in_b_q, in_b_d;
    logic [CODE_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]           chan_shdn_q, chan_shdn_d;
    logic                 pos_valid_q, pos_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;

    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign latchn_s = latchn_sync_q[SYNC_STAGES-1];

    assign csn_rise    = csn_s & ~csn_prev_q;
    assign csn_fall    = ~csn_s & csn_prev_q;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign latchn_fall = ~latchn_s & latchn_prev_q;

    // Synchronizers. csn resets low so a frame already in progress at reset
    // release is not mistaken for an idle bus; latchn resets high so no
    // spurious latch edge appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csn_sync_q    <= '0;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            latchn_sync_q <= '1;
            csn_prev_q    <= 1'b0;
            sclk_prev_q   <= 1'b0;
            latchn_prev_q <= 1'b1;
        end else begin
            csn_sync_q    <= {csn_sync_q[SYNC_STAGES-2:0], bus.dac_csn};
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], bus.dac_sclk};
            mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], bus.dac_mosi};
            latchn_sync_q <= {latchn_sync_q[SYNC_STAGES-2:0], bus.dac_latchn};
            csn_prev_q    <= csn_s;
            sclk_prev_q   <= sclk_s;
            latchn_prev_q <= latchn_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            chan_shdn_q <= 2'b11;
            pos_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            chan_shdn_q <= chan_shdn_d;
            pos_valid_q <= pos_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Frame FSM, commit and latch transfer
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        in_a_d      = in_a_q;
        in_b_d      = in_b_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        chan_shdn_d = chan_shdn_q;
        pos_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        unique case (state_q)
            WAIT_IDLE: begin
                if (csn_s) state_d = IDLE;
            end
            IDLE: begin
                if (csn_fall) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = {shreg_q[WORD_BITS-2:0], mosi_s};
                    if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
                end
                if (csn_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(WORD_BITS)) begin
                        if (shreg_q[CHAN_BIT]) begin
                            in_b_d.shdn_n = shreg_q[SHDN_BIT];
                            in_b_d.code   = shreg_q[CODE_W-1:0];
                        end else begin
                            in_a_d.shdn_n = shreg_q[SHDN_BIT];
                            in_a_d.code   = shreg_q[CODE_W-1:0];
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        // Latch reads the next-state input registers so a commit in the same
        // cycle is forwarded to the outputs.
        if (latchn_fall) begin
            pos_x_d     = in_a_d.code;
            pos_y_d     = in_b_d.code;
            chan_shdn_d = {~in_b_d.shdn_n, ~in_a_d.shdn_n};
            pos_valid_d = 1'b1;
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.pos_valid = pos_valid_q;
    assign bus.chan_shdn = chan_shdn_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_dac_spi_monitor.sv
// Bench for dac_spi_monitor: drives the SPI pins, tracks the DAC semantics in
// a pin-level model and compares every cycle's outputs after a fixed latency.
module tb_dac_spi_monitor;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    dac_spi_monitor_if bus ();

    dac_spi_monitor #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    localparam int LAT = 3;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    always @(posedge clk) cyc++;

    typedef struct {
        int         at;
        bit         is_latch;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  sh;
    } ev_t;
    ev_t evq[$];

    // DAC model state
    logic [11:0] m_a_code, m_b_code;
    logic        m_a_shn, m_b_shn;
    bit          m_in_frame;
    int          m_nbits;
    logic [15:0] m_word;

    // Expected outputs
    logic [11:0] e_x, e_y;
    logic [1:0]  e_sh;
    logic        e_valid, e_err;
    int          e_cnt;

    int valid_seen = 0;
    int last_valid_cyc = 0;
    int last_latch_cyc = 0;
    int v0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        evq.delete();
        m_a_code = '0; m_b_code = '0; m_a_shn = 1'b0; m_b_shn = 1'b0;
        m_in_frame = 1'b0; m_nbits = 0; m_word = '0;
        e_x = '0; e_y = '0; e_sh = 2'b11; e_valid = 1'b0; e_err = 1'b0; e_cnt = 0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (checking) begin
            e_valid = 1'b0;
            e_err   = 1'b0;
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                e = evq.pop_front();
                if (e.is_latch) begin
                    e_x = e.x; e_y = e.y; e_sh = e.sh; e_valid = 1'b1;
                end else begin
                    e_err = 1'b1;
                    if (e_cnt < 255) e_cnt++;
                end
            end
            check("pos_x", 32'(bus.pos_x), 32'(e_x));
            check("pos_y", 32'(bus.pos_y), 32'(e_y));
            check("chan_shdn", 32'(bus.chan_shdn), 32'(e_sh));
            check("pos_valid", 32'(bus.pos_valid), 32'(e_valid));
            check("frame_err", 32'(bus.frame_err), 32'(e_err));
            check("err_count", 32'(bus.err_count), 32'(e_cnt));
            if (bus.pos_valid === 1'b1) begin
                valid_seen++;
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_ev(input bit is_latch);
        ev_t e;
        e.at = cyc + LAT;
        e.is_latch = is_latch;
        e.x  = m_a_code;
        e.y  = m_b_code;
        e.sh = {~m_b_shn, ~m_a_shn};
        evq.push_back(e);
    endtask

    task automatic csn_fall();
        bus.dac_csn = 1'b0;
        m_in_frame = 1'b1; m_nbits = 0; m_word = '0;
    endtask

    task automatic csn_rise();
        bus.dac_csn = 1'b1;
        if (m_in_frame) begin
            if (m_nbits == 16) begin
                if (m_word[15]) begin m_b_code = m_word[11:0]; m_b_shn = m_word[12]; end
                else            begin m_a_code = m_word[11:0]; m_a_shn = m_word[12]; end
            end else begin
                push_ev(1'b0);
            end
            m_in_frame = 1'b0;
        end
    endtask

    task automatic latch_fall();
        bus.dac_latchn = 1'b0;
        last_latch_cyc = cyc;
        push_ev(1'b1);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int lo, input int hi);
        for (int i = n - 1; i >= 0; i--) begin
            bus.dac_mosi = w[i];
            step(lo);
            bus.dac_sclk = 1'b1;
            if (m_in_frame) begin
                m_nbits++;
                m_word = {m_word[14:0], w[i]};
            end
            step(hi);
            bus.dac_sclk = 1'b0;
        end
        step(lo);
    endtask

    task automatic frame(input logic [31:0] w, input int n, input int lo, input int hi, input int gap);
        csn_fall();
        step(2);
        send_bits(w, n, lo, hi);
        csn_rise();
        step(gap);
    endtask

    task automatic latch();
        latch_fall();
        step(3);
        bus.dac_latchn = 1'b1;
        step(3);
    endtask

    initial begin
        bus.dac_csn = 1'b1; bus.dac_sclk = 1'b0; bus.dac_mosi = 1'b0; bus.dac_latchn = 1'b1;
        model_reset();
        #2 reset = 1'b1;
        step(3);
        checking = 1'b1;
        step(1);
        check("rst_chan_shdn", 32'(bus.chan_shdn), 32'h3);
        check("rst_err_count", 32'(bus.err_count), 32'h0);
        reset = 1'b0;
        step(6);

        // Commit without latch stays hidden
        frame(32'h1ABC, 16, 2, 2, 4);
        step(4);
        check("nolatch_x", 32'(bus.pos_x), 32'h0);
        check("nolatch_valid_cnt", 32'(valid_seen), 32'h0);
        latch();
        check("latch_x", 32'(bus.pos_x), 32'hABC);

        // Both channels then one latch
        frame(32'h1ABC, 16, 2, 2, 3);
        frame(32'h9123, 16, 3, 2, 3);
        v0 = valid_seen;
        latch();
        step(2);
        check("dual_x", 32'(bus.pos_x), 32'hABC);
        check("dual_y", 32'(bus.pos_y), 32'h123);
        check("dual_shdn", 32'(bus.chan_shdn), 32'h0);
        check("valid_pulses", 32'(valid_seen - v0), 32'h1);
        check("valid_latency", 32'(last_valid_cyc - last_latch_cyc), 32'h3);

        // Short and long frames
        frame(32'h0000_0F0F, 12, 2, 2, 3);
        frame(32'h000F_5A5A, 20, 2, 3, 3);
        step(3);
        check("bad_err_count", 32'(bus.err_count), 32'h2);
        latch();
        check("bad_keep_x", 32'(bus.pos_x), 32'hABC);
        check("bad_keep_y", 32'(bus.pos_y), 32'h123);

        // Channel B shut down, then error counter saturation
        frame(32'h8000, 16, 2, 2, 3);
        latch();
        check("shdn_b", 32'(bus.chan_shdn), 32'h2);
        check("shdn_y", 32'(bus.pos_y), 32'h0);
        check("shdn_x", 32'(bus.pos_x), 32'hABC);
        for (int i = 0; i < 300; i++) frame(32'h1, 1, 2, 2, 2);
        step(4);
        check("sat_err_count", 32'(bus.err_count), 32'hFF);

        // Reset in the middle of a frame
        reset = 1'b1; model_reset(); step(3); reset = 1'b0; step(6);
        csn_fall();
        step(2);
        send_bits(32'h12, 8, 2, 2);
        reset = 1'b1;
        model_reset();
        step(3);
        reset = 1'b0;
        step(2);
        send_bits(32'h34, 8, 2, 2);
        csn_rise();
        step(6);
        check("midrst_err", 32'(bus.err_count), 32'h0);
        frame(32'h1055, 16, 2, 2, 3);
        latch();
        check("midrst_x", 32'(bus.pos_x), 32'h055);

        // csn rise and latch fall on the same cycle
        csn_fall();
        step(2);
        send_bits(32'h1FFF, 16, 2, 2);
        csn_rise();
        latch_fall();
        step(3);
        bus.dac_latchn = 1'b1;
        step(4);
        check("fwd_x", 32'(bus.pos_x), 32'hFFF);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                latch();
            end else begin
                int n;
                logic [31:0] w;
                n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 24)) : 16;
                w = $urandom;
                if (r == 9) begin
                    csn_fall();
                    step(2);
                    send_bits(w, n, 2, 2);
                    csn_rise();
                    latch_fall();
                    step(3);
                    bus.dac_latchn = 1'b1;
                    step(3);
                end else begin
                    frame(w, n, int'($urandom_range(2, 4)), int'($urandom_range(2, 4)),
                          int'($urandom_range(2, 5)));
                end
            end
        end
        step(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
